mod_mul_interleaved: RTL
========================

# mod_mul_interleaved

Sequential modular multiplier that computes oData = (iA × iB) mod iMod by MSB-first interleaved double-and-add, one multiplier bit per cycle. It sits directly downstream of the registered modular doubler stage and consumes that stage's arithmetic, 2·x mod M, as its per-iteration doubling step. It adds the conditional modular add and the iteration control around it. Operands enter and the result leaves through valid/ready handshakes, so the block drops into the modular datapath pipeline.

## Interface
- BITWIDTH, 32, width of operands, modulus and result
- CNTW, $clog2(BITWIDTH), width of the bit-iteration counter
- iClk  input  1  clock, rising edge
- iRstN  input  1  reset, asynchronous, active-low
- iClr  input  1  synchronous clear; aborts any operation
- iValid  input  1  operand triple valid
- oReady  output  1  block can accept operands (high only in IDLE)
- iA  input  BITWIDTH  multiplicand; must satisfy iA < iMod
- iB  input  BITWIDTH  multiplier; any value
- iMod  input  BITWIDTH  modulus; must satisfy iMod ≥ 1
- oValid  output  1  result valid
- iReady  input  1  consumer accepts result
- oData  output  BITWIDTH  (iA × iB) mod iMod

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE**
  - oReady=1.
  - On iValid at a rising edge: latch A, B and M; set acc=0 and cnt=BITWIDTH-1; go to RUN.
- **RUN**
  - Each cycle, with b = B[cnt]:
    - d = 2·acc, held at BITWIDTH+1 bits.
    - If d ≥ M then d = d − M.
    - s = d + (b ? A : 0), held at BITWIDTH+1 bits.
    - If s ≥ M then s = s − M.
    - acc ← s[BITWIDTH-1:0].
  - If cnt==0, go to DONE; otherwise decrement cnt.
- **DONE**
  - oValid=1 and oData=acc.
  - On iReady at a rising edge: go to IDLE and drop oValid.
- **Invariant:** acc < M after every RUN cycle. Both comparisons are unsigned at BITWIDTH+1 bits. No intermediate value exceeds 2M−1 < 2^(BITWIDTH+1).
- **iClr** (highest priority below reset):
  - Next state is IDLE; acc=0, cnt=0, oValid=0.
  - An iValid arriving in the same cycle is not accepted.
- **Operand capture:** operand inputs are sampled only on the accept edge. Changes to iA, iB or iMod during RUN or DONE have no effect.
- **Preconditions are not checked.** If iA ≥ iMod, oData is unspecified, but the FSM still completes and handshakes normally.

## Timing
- **Reset values:** state=IDLE, oReady=1, oValid=0, oData=0; internal A, B, M, acc, cnt all 0.
- **Latency:** accept at edge T0; RUN occupies cycles T0..T0+BITWIDTH-1; oValid rises right after edge T0+BITWIDTH.
  - BITWIDTH=32: oValid rises 32 cycles after acceptance.
- **Throughput:** one result per BITWIDTH+2 cycles when iValid and iReady are held high: one IDLE cycle, BITWIDTH RUN cycles, one DONE cycle.
- **Backpressure:** oValid and oData hold stable while iReady is low.
- oReady is combinational from state only, never from iValid.
- oValid and oData are driven from registers.
- **Reset mid-RUN:** immediately asynchronous, returning to IDLE with all outputs at their reset values.
- **Boundary conditions:**
  - iB=0 yields 0.
  - iMod=1 yields 0.
  - iB MSB set is processed in the first RUN cycle.

## Structure
- Shared package mod_pkg:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} mod_mul_state_t.
  - Function mod_reduce1(x, m) (single conditional subtract, BITWIDTH+1 bits), reused by the doubler and adder stages.
- One natural sub-module: mod_dbl_add_step, a purely combinational block.
  - Inputs: acc, A, M, b.
  - Output: the next acc, computed as ((2·acc mod M) + b·A) mod M.
  - The top level holds the FSM, counter and operand registers.

## Test plan
BITWIDTH=32 throughout.
- **Basic:** reset, then iA=5, iB=7, iMod=23 with iReady=1 → oValid exactly 32 cycles after acceptance, oData=12; oReady low throughout RUN and DONE.
- **Wrap cases:**
  - iA=22, iB=22, iMod=23 → 1.
  - iA=1, iB=0xFFFFFFFF, iMod=23 → 11.
  - iA=7, iB=0, iMod=23 → 0.
- **Wide modulus:** iMod=0xFFFFFFFB, iA=iB=0xFFFFFFFA → 1, exercising the 33-bit intermediates.
- **Backpressure:** hold iReady=0 for 10 cycles after oValid → oData stays 12 and oValid stays 1; raise iReady → next cycle oValid=0 and oReady=1.
- **Abort:**
  - Assert iClr at RUN cycle 10 → next cycle IDLE, oValid=0, acc=0.
  - Separately, deassert iRstN at RUN cycle 5 → outputs go to reset values immediately.
  - A following operation computes correctly in both cases.
- **Random:** 100 back-to-back random operations with iMod=23, iA in [0,22], iB random, iValid and iReady always 1 → every oData equals (iA·iB)%iMod; one result per 34 cycles.

Source files
------------

// File: rtl/mod_pkg.sv
// mod_pkg: shared types and helpers for the modular arithmetic datapath.
package mod_pkg;
    localparam int MOD_BW = 32;
    typedef enum logic [1:0] {IDLE, RUN, DONE} mod_mul_state_t;
    // Single conditional subtract; valid whenever x < 2*m.
    function automatic logic [MOD_BW:0] mod_reduce1(input logic [MOD_BW:0] x, input logic [MOD_BW:0] m);
        return (x >= m) ? x - m : x;
    endfunction
endpackage

// File: rtl/mod_dbl_add_step.sv
// mod_dbl_add_step: one interleaved iteration, ((2*acc mod M) + b*A) mod M.
module mod_dbl_add_step
    import mod_pkg::*;
#(
    parameter int BITWIDTH = MOD_BW
) (
    input  logic [BITWIDTH-1:0] acc_i,
    input  logic [BITWIDTH-1:0] a_i,
    input  logic [BITWIDTH-1:0] m_i,
    input  logic                b_i,
    output logic [BITWIDTH-1:0] acc_o
);
    logic [BITWIDTH:0] m_x;
    logic [BITWIDTH:0] dbl;
    logic [BITWIDTH:0] sum;
    // Intermediates stay below 2M, so one extra bit and one subtract suffice.
    assign m_x   = {1'b0, m_i};
    assign dbl   = mod_reduce1({acc_i, 1'b0}, m_x);
    assign sum   = dbl + (b_i ? {1'b0, a_i} : '0);
    assign acc_o = BITWIDTH'(mod_reduce1(sum, m_x));
endmodule

// File: rtl/mod_mul_interleaved.sv
// mod_mul_interleaved: sequential (A*B) mod M, MSB-first double-and-add,
// one multiplier bit per cycle behind valid/ready handshakes.
module mod_mul_interleaved
    import mod_pkg::*;
#(
    parameter int BITWIDTH = MOD_BW,
    parameter int CNTW     = $clog2(BITWIDTH)
) (
    input  logic                iClk,
    input  logic                iRstN,
    input  logic                iClr,
    input  logic                iValid,
    output logic                oReady,
    input  logic [BITWIDTH-1:0] iA,
    input  logic [BITWIDTH-1:0] iB,
    input  logic [BITWIDTH-1:0] iMod,
    output logic                oValid,
    input  logic                iReady,
    output logic [BITWIDTH-1:0] oData
);
    mod_mul_state_t    state_q;
    logic [BITWIDTH-1:0] a_q, b_q, m_q, acc_q, acc_d;
    logic [CNTW-1:0]     cnt_q;
    logic                valid_q;

    mod_dbl_add_step #(.BITWIDTH(BITWIDTH)) u_step (
        .acc_i(acc_q),
        .a_i  (a_q),
        .m_i  (m_q),
        .b_i  (b_q[cnt_q]),
        .acc_o(acc_d)
    );

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            m_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else if (iClr) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (iValid) begin
                    a_q     <= iA;
                    b_q     <= iB;
                    m_q     <= iMod;
                    acc_q   <= '0;
                    cnt_q   <= CNTW'(BITWIDTH - 1);
                    state_q <= RUN;
                end
                RUN: begin
                    acc_q <= acc_d;
                    if (cnt_q == '0) begin
                        state_q <= DONE;
                        valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                DONE: if (iReady) begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign oReady = (state_q == IDLE);
    assign oValid = valid_q;
    assign oData  = acc_q;
endmodule
